// File: rtl/adc_frame_pkg.sv
// rtl/adc_frame_pkg.sv - shared constants and FSM encoding for the ADC frame builder
package adc_frame_pkg;

   localparam logic [7:0] SYNC0  = 8'hAA;
   localparam logic [7:0] SYNC1  = 8'h55;
   localparam int         MAX_CH = 64;
   localparam int         IDX_W  = 6;

   // Each state names the byte currently presented on TX_DATA.
   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_HDR0  = 4'd1;
   localparam logic [3:0] ST_HDR1  = 4'd2;
   localparam logic [3:0] ST_SEQ   = 4'd3;
   localparam logic [3:0] ST_CNT   = 4'd4;
   localparam logic [3:0] ST_CH_ID = 4'd5;
   localparam logic [3:0] ST_CH_HI = 4'd6;
   localparam logic [3:0] ST_CH_LO = 4'd7;
   localparam logic [3:0] ST_CSUM  = 4'd8;

endpackage

// File: rtl/adc_frame_builder_ch_mask_scan.sv
// rtl/adc_frame_builder_ch_mask_scan.sv - lowest-set-bit index and any-set flag over a channel mask
module ch_mask_scan
   import adc_frame_pkg::*;
#(
   parameter int N_CH = 16
) (
   input  logic [N_CH-1:0]  mask,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scanning downward lets the lowest set bit be the last assignment.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_frame_builder.sv
// rtl/adc_frame_builder.sv - decimated ADC snapshot serialised into a checksummed byte frame
module adc_frame_builder
   import adc_frame_pkg::*;
#(
   parameter int N_CH    = 16,
   parameter int DATA_W  = 16,
   parameter int DECIM_W = 16
) (
   input  logic                   CLK,
   input  logic                   RESET_n,
   input  logic [N_CH*DATA_W-1:0] CH_DATA,
   input  logic [N_CH-1:0]        CH_EN,
   input  logic                   TRIG,
   input  logic [DECIM_W-1:0]     DECIM,
   input  logic                   MODE,
   input  logic                   ARM,
   output logic [7:0]             TX_DATA,
   output logic                   TX_VALID,
   input  logic                   TX_READY,
   output logic                   BUSY,
   output logic                   OVERRUN,
   output logic [7:0]             FRAME_CNT
);

   logic [3:0]             state;
   logic [DECIM_W-1:0]     dec_cnt;
   logic                   armed;
   logic [N_CH*DATA_W-1:0] snap_data;
   logic [N_CH-1:0]        mask;
   logic [N_CH-1:0]        mask_rest;
   logic [7:0]             cnt_byte;
   logic [7:0]             csum;
   logic [7:0]             en_count;
   logic [IDX_W-1:0]       cur_idx;
   logic                   cur_any;
   logic [IDX_W-1:0]       nxt_idx;
   logic                   nxt_any;
   logic [7:0]             cur_id_byte;
   logic [7:0]             nxt_id_byte;
   logic [15:0]            cur_sample;
   logic                   qual;
   logic                   accept;
   logic                   xfer;

   assign qual        = TRIG && (dec_cnt == DECIM);
   assign accept      = qual && (state == ST_IDLE) && (!MODE || armed);
   assign xfer        = TX_VALID && TX_READY;
   assign mask_rest   = mask & (mask - N_CH'(1));
   assign cur_id_byte = {{(8-IDX_W){1'b0}}, cur_idx};
   assign nxt_id_byte = {{(8-IDX_W){1'b0}}, nxt_idx};

   ch_mask_scan #(.N_CH(N_CH)) u_scan_cur (
      .mask (mask),
      .idx  (cur_idx),
      .any  (cur_any)
   );

   // Lookahead past the current channel, used on its CH_LO transfer.
   ch_mask_scan #(.N_CH(N_CH)) u_scan_nxt (
      .mask (mask_rest),
      .idx  (nxt_idx),
      .any  (nxt_any)
   );

   always_comb begin
      en_count = '0;
      for (int i = 0; i < N_CH; i++) begin
         en_count = en_count + 8'(CH_EN[i]);
      end
   end

   always_comb begin
      cur_sample = 16'(snap_data[int'(cur_idx)*DATA_W +: DATA_W]);
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         dec_cnt <= '0;
      end else if (TRIG) begin
         dec_cnt <= qual ? '0 : dec_cnt + DECIM_W'(1);
      end
   end

   // A new overrun outranks a simultaneous ARM clear.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         armed   <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         if (ARM) begin
            armed <= 1'b1;
         end else if (accept) begin
            armed <= 1'b0;
         end
         if (qual && BUSY) begin
            OVERRUN <= 1'b1;
         end else if (ARM) begin
            OVERRUN <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state     <= ST_IDLE;
         TX_DATA   <= 8'h00;
         TX_VALID  <= 1'b0;
         BUSY      <= 1'b0;
         FRAME_CNT <= 8'h00;
         snap_data <= '0;
         mask      <= '0;
         cnt_byte  <= 8'h00;
         csum      <= 8'h00;
      end else if (accept) begin
         snap_data <= CH_DATA;
         mask      <= CH_EN;
         cnt_byte  <= en_count;
         TX_DATA   <= SYNC0;
         TX_VALID  <= 1'b1;
         BUSY      <= 1'b1;
         state     <= ST_HDR0;
      end else if (xfer) begin
         case (state)
            ST_HDR0: begin
               TX_DATA <= SYNC1;
               state   <= ST_HDR1;
            end
            ST_HDR1: begin
               TX_DATA <= FRAME_CNT;
               csum    <= FRAME_CNT;
               state   <= ST_SEQ;
            end
            ST_SEQ: begin
               TX_DATA <= cnt_byte;
               csum    <= csum ^ cnt_byte;
               state   <= ST_CNT;
            end
            ST_CNT: begin
               if (cur_any) begin
                  TX_DATA <= cur_id_byte;
                  csum    <= csum ^ cur_id_byte;
                  state   <= ST_CH_ID;
               end else begin
                  TX_DATA <= csum;
                  state   <= ST_CSUM;
               end
            end
            ST_CH_ID: begin
               TX_DATA <= cur_sample[15:8];
               csum    <= csum ^ cur_sample[15:8];
               state   <= ST_CH_HI;
            end
            ST_CH_HI: begin
               TX_DATA <= cur_sample[7:0];
               csum    <= csum ^ cur_sample[7:0];
               state   <= ST_CH_LO;
            end
            ST_CH_LO: begin
               mask <= mask_rest;
               if (nxt_any) begin
                  TX_DATA <= nxt_id_byte;
                  csum    <= csum ^ nxt_id_byte;
                  state   <= ST_CH_ID;
               end else begin
                  TX_DATA <= csum;
                  state   <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               TX_VALID  <= 1'b0;
               BUSY      <= 1'b0;
               FRAME_CNT <= FRAME_CNT + 8'd1;
               state     <= ST_IDLE;
            end
            default: begin
               TX_VALID <= 1'b0;
               BUSY     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_frame_builder.sv
// tb/tb_adc_frame_builder.sv - scoreboard bench for adc_frame_builder
module tb_adc_frame_builder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] ch_data;
   logic [15:0]  ch_en;
   logic         trig;
   logic [15:0]  decim;
   logic         mode;
   logic         arm;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic         overrun;
   logic [7:0]   frame_cnt;

   int           pass_cnt   = 0;
   int           total_cnt  = 0;
   int           stab_err   = 0;
   int           bubble_err = 0;
   logic [7:0]   exp_q[$];
   logic [7:0]   obs_q[$];
   logic         held = 1'b0;
   logic [7:0]   held_data = 8'h00;

   always #5 clk = ~clk;

   adc_frame_builder #(.N_CH(16), .DATA_W(16), .DECIM_W(16)) dut (
      .CLK       (clk),
      .RESET_n   (rst_n),
      .CH_DATA   (ch_data),
      .CH_EN     (ch_en),
      .TRIG      (trig),
      .DECIM     (decim),
      .MODE      (mode),
      .ARM       (arm),
      .TX_DATA   (tx_data),
      .TX_VALID  (tx_valid),
      .TX_READY  (tx_ready),
      .BUSY      (busy),
      .OVERRUN   (overrun),
      .FRAME_CNT (frame_cnt)
   );

   always @(negedge clk) begin
      if (!rst_n) begin
         held <= 1'b0;
      end else begin
         if (held && (!tx_valid || tx_data !== held_data)) stab_err <= stab_err + 1;
         if (busy && !tx_valid) bubble_err <= bubble_err + 1;
         if (tx_valid && tx_ready) begin
            obs_q.push_back(tx_data);
            held <= 1'b0;
         end else if (tx_valid) begin
            held      <= 1'b1;
            held_data <= tx_data;
         end else begin
            held <= 1'b0;
         end
      end
   end

   task automatic push_frame(input logic [7:0] seq);
      logic [7:0] n;
      logic [7:0] cs;
      logic [7:0] b;
      n = 8'h00;
      for (int i = 0; i < 16; i++) if (ch_en[i]) n = n + 8'd1;
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      exp_q.push_back(seq);
      exp_q.push_back(n);
      cs = seq ^ n;
      for (int i = 0; i < 16; i++) begin
         if (ch_en[i]) begin
            b = 8'(i);
            exp_q.push_back(b); cs = cs ^ b;
            b = ch_data[i*16+8 +: 8];
            exp_q.push_back(b); cs = cs ^ b;
            b = ch_data[i*16 +: 8];
            exp_q.push_back(b); cs = cs ^ b;
         end
      end
      exp_q.push_back(cs);
   endtask

   function automatic int first_mismatch();
      if (obs_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic do_trig();
      trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd);
      int n;
      n = 0;
      while ((busy || tx_valid) && n < 3000) begin
         @(posedge clk); #1;
         if (rnd) tx_ready = ($urandom_range(0, 99) < 30);
         n++;
      end
      tx_ready = 1'b1;
      if (n >= 3000) begin
         total_cnt++;
         $display("FAIL wait_idle: frame still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      trig = 1'b0; arm = 1'b0; tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; trig = 1'b0; arm = 1'b0; tx_ready = 1'b1;
      mode = 1'b0; decim = 16'd0; ch_en = 16'h0000; ch_data = '0;
      #2;
      total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid); else pass_cnt++;
      total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (frame_cnt !== 8'h00) $display("FAIL reset_frame_cnt: got %h want 00", frame_cnt); else pass_cnt++;
      apply_reset();
   endtask

   task automatic test_basic();
      int mm;
      apply_reset();
      ch_data = '0;
      ch_data[15:0]  = 16'h1234;
      ch_data[47:32] = 16'h00AB;
      ch_en = 16'h0005;
      do_trig();
      push_frame(8'h00);
      total_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA || busy !== 1'b1)
         $display("FAIL basic_latency: got valid=%b data=%h busy=%b want 1 AA 1", tx_valid, tx_data, busy);
      else pass_cnt++;
      wait_idle(1'b0);
      total_cnt++;
      if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 8'h8D)
         $display("FAIL basic_csum: got %0d bytes, last byte wrong, want 8d", obs_q.size());
      else pass_cnt++;
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL basic_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      total_cnt++; if (frame_cnt !== 8'h01) $display("FAIL basic_frame_cnt: got %h want 01", frame_cnt); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_decim();
      int tb_dec;
      int frames;
      bit q;
      int mm;
      apply_reset();
      decim = 16'd3;
      tb_dec = 0;
      frames = 0;
      for (int k = 0; k < 8; k++) begin
         q = (tb_dec == 3);
         tb_dec = q ? 0 : tb_dec + 1;
         do_trig();
         if (q) begin
            push_frame(8'(frames));
            frames++;
         end
         total_cnt++; if (busy !== q) $display("FAIL decim_start_%0d: got busy=%b want %b", k, busy, q); else pass_cnt++;
         repeat (200) @(posedge clk);
         #1;
      end
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL decim_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      total_cnt++; if (frame_cnt !== 8'h02) $display("FAIL decim_frame_cnt: got %h want 02", frame_cnt); else pass_cnt++;
      decim = 16'd0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_backpressure();
      int mm;
      apply_reset();
      stab_err = 0;
      bubble_err = 0;
      do_trig();
      push_frame(8'h00);
      wait_idle(1'b1);
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL bp_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      total_cnt++; if (stab_err != 0) $display("FAIL bp_stable: got %0d unstable holds want 0", stab_err); else pass_cnt++;
      total_cnt++; if (bubble_err != 0) $display("FAIL bp_bubble: got %0d bubbles want 0", bubble_err); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_single_shot();
      int mm;
      apply_reset();
      mode = 1'b1;
      do_trig();
      repeat (30) @(posedge clk);
      #1;
      total_cnt++; if (obs_q.size() != 0 || busy !== 1'b0) $display("FAIL ss_unarmed: got %0d bytes busy=%b want 0 0", obs_q.size(), busy); else pass_cnt++;
      do_arm();
      do_trig();
      push_frame(8'h00);
      wait_idle(1'b0);
      do_trig();
      repeat (30) @(posedge clk);
      #1;
      arm = 1'b1; trig = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0; trig = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL ss_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      total_cnt++; if (frame_cnt !== 8'h01) $display("FAIL ss_frame_cnt: got %h want 01", frame_cnt); else pass_cnt++;
      mode = 1'b0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overrun();
      int mm;
      apply_reset();
      ch_en = 16'h0005;
      do_trig();
      push_frame(8'h00);
      repeat (3) @(posedge clk);
      #1;
      do_trig();
      total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else pass_cnt++;
      wait_idle(1'b0);
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL ovr_intact: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
      do_arm();
      total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_arm_clear: got %b want 0", overrun); else pass_cnt++;
      do_trig();
      push_frame(8'h01);
      repeat (2) @(posedge clk);
      #1;
      arm = 1'b1; trig = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0; trig = 1'b0;
      total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b want 1", overrun); else pass_cnt++;
      wait_idle(1'b0);
      do_arm();
      ch_en = 16'h0000;
      do_trig();
      push_frame(8'h02);
      repeat (4) @(posedge clk);
      #1;
      do_trig();
      total_cnt++; if (overrun !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0)
         $display("FAIL ovr_csum_cycle: got ovr=%b busy=%b valid=%b want 1 0 0", overrun, busy, tx_valid);
      else pass_cnt++;
      repeat (20) @(posedge clk);
      #1;
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL ovr_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_empty_and_reset();
      int mm;
      apply_reset();
      ch_en = 16'h0000;
      do_trig();
      exp_q.push_back(8'hAA); exp_q.push_back(8'h55); exp_q.push_back(8'h00);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      wait_idle(1'b0);
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL empty_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
      ch_en = 16'h0005;
      do_trig();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      total_cnt++; if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || frame_cnt !== 8'h00)
         $display("FAIL midframe_reset: got valid=%b busy=%b data=%h cnt=%h want 0 0 00 00", tx_valid, busy, tx_data, frame_cnt);
      else pass_cnt++;
      @(posedge clk); #1 rst_n = 1'b1;
      obs_q.delete();
      do_trig();
      push_frame(8'h00);
      wait_idle(1'b0);
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL post_reset_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wrap();
      int mm;
      apply_reset();
      ch_en = 16'h0000;
      for (int f = 0; f < 256; f++) begin
         do_trig();
         push_frame(8'(f));
         wait_idle(1'b0);
         if (f == 254) begin
            total_cnt++; if (frame_cnt !== 8'hFF) $display("FAIL wrap_255: got %h want ff", frame_cnt); else pass_cnt++;
         end
      end
      total_cnt++; if (frame_cnt !== 8'h00) $display("FAIL wrap_0: got %h want 00", frame_cnt); else pass_cnt++;
      mm = first_mismatch();
      total_cnt++; if (mm != -1) $display("FAIL wrap_stream: mismatch %0d got %0d bytes want %0d", mm, obs_q.size(), exp_q.size()); else pass_cnt++;
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decim();
      test_backpressure();
      test_single_shot();
      test_overrun();
      test_empty_and_reset();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
